// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: sequences INIT/ROUND/ADD across up to three
// 64-round blocks (two header blocks plus the hash-of-hash block).
// Optional feature macro: MIDSTATE_REUSE_EN caches the block-0 midstate so a
// follow-up job can skip block 0.
module sha256_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       reuse_mid,
  input  logic       abort,
  input  logic       word_valid,
  output logic       word_ready,
  output logic [6:0] select,
  output logic [1:0] block,
  output logic       control,
  output logic       iter_en,
  output logic       hash_add,
  output logic       busy,
  output logic       done,
  output logic       midstate_valid
);

  localparam int unsigned SEL_W      = 7;
  localparam int unsigned BLK_W      = 2;
  localparam int unsigned MSG_ROUNDS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic             mid_q;
  logic             msg_phase;

`ifdef MIDSTATE_REUSE_EN
  logic mid_d;

  // Midstate-valid flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mid_q <= 1'b0;
    else     mid_q <= mid_d;
  end
`else
  logic unused_reuse_mid;
  assign unused_reuse_mid = reuse_mid;
  assign mid_q            = 1'b0;
`endif

  // State, round index and block index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      select_q <= '0;
      block_q  <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      block_q  <= block_d;
    end
  end

  // Message words are consumed only in the first 16 rounds of header blocks
  assign msg_phase = (state_q == S_ROUND) && (select_q <= SEL_W'(MSG_ROUNDS)) &&
                     (block_q != BLK_W'(2));

  // Next-state and strobe decode
  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    block_d    = block_q;
    control    = 1'b0;
    iter_en    = 1'b0;
    hash_add   = 1'b0;
    word_ready = 1'b0;
    done       = 1'b0;
`ifdef MIDSTATE_REUSE_EN
    mid_d      = mid_q;
`endif

    case (state_q)
      S_IDLE: begin
        select_d = '0;
        block_d  = '0;
        if (start && !abort) begin
          state_d = S_INIT;
`ifdef MIDSTATE_REUSE_EN
          if (reuse_mid && mid_q) block_d = BLK_W'(1);
          if (!reuse_mid)         mid_d   = 1'b0;
`endif
        end
      end
      S_INIT: begin
        control  = 1'b1;
        select_d = SEL_W'(1);
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        word_ready = msg_phase;
        iter_en    = msg_phase ? word_valid : 1'b1;
        if (iter_en) begin
          if (select_q == SEL_W'(NUM_ROUNDS)) begin
            select_d = '0;
            state_d  = S_ADD;
          end else begin
            select_d = select_q + SEL_W'(1);
          end
        end
      end
      S_ADD: begin
        hash_add = 1'b1;
        if (block_q != BLK_W'(2)) begin
          block_d = block_q + BLK_W'(1);
          state_d = S_INIT;
`ifdef MIDSTATE_REUSE_EN
          if (block_q == '0) mid_d = 1'b1;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        block_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        select_d = '0;
        block_d  = '0;
      end
    endcase

    // Abort cancels the job and suppresses this cycle's strobes
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      select_d   = '0;
      block_d    = '0;
      control    = 1'b0;
      iter_en    = 1'b0;
      hash_add   = 1'b0;
      word_ready = 1'b0;
      done       = 1'b0;
`ifdef MIDSTATE_REUSE_EN
      if (block_q == '0) mid_d = 1'b0;
`endif
    end
  end

  assign select         = select_q;
  assign block          = block_q;
  assign busy           = (state_q != S_IDLE);
  assign midstate_valid = mid_q;

endmodule
